// File: rtl/dualrail_pkg.sv
// Shared definitions for the dual-rail word receiver.
//   state_t : receiver FSM states (wait for symbol, ack symbol, output word,
//             word-level ack).
//   SYM_*   : rail symbol encodings, ordered {bit1, bit0}.
package dualrail_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACK    = 2'd1,
    ST_OUT    = 2'd2,
    ST_SENACK = 2'd3
  } state_t;

  localparam logic [1:0] SYM_NULL = 2'b00;
  localparam logic [1:0] SYM_0    = 2'b01;
  localparam logic [1:0] SYM_1    = 2'b10;
  localparam logic [1:0] SYM_ERR  = 2'b11;

endpackage

// File: rtl/sync_bits.sv
// Multi-flop synchroniser for a group of asynchronous single-bit signals.
// Each bit is synchronised independently; the rails are return-to-zero, so
// bits skewing by a cycle against each other is harmless downstream.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high, clears every stage to 0
//   d     : asynchronous inputs
//   q     : synchronised outputs (STAGES cycles after d)
module sync_bits #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/dualrail_word_rx.sv
// Dual-rail return-to-zero word receiver.
// Takes one dual-rail symbol at a time from the bit sender, acknowledges each
// with a 4-phase ack, shifts data bits in LSB-first, and on the word-end
// strobe (dt) presents the word to a valid/ready consumer before returning
// the word-level senack.
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   bit0_in, bit1_in : async data rails (01 = logic 0, 10 = logic 1)
//   dt_in            : async word-end strobe
//   ack_out          : per-symbol 4-phase ack
//   senack_out       : word-level ack, held until dt falls
//   rx_data          : assembled word, first bit received at rx_data[0]
//   rx_valid         : word available
//   rx_ready         : consumer accepts word
//   err_out          : one-cycle pulse on illegal symbol, overrun or short word
//   state_dbg        : current FSM state
// Handshake: a word transfers on a clock edge where rx_valid and rx_ready are
// both high; once rx_valid rises it and rx_data stay unchanged until that edge.
module dualrail_word_rx
  import dualrail_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit0_in,
  input  logic              bit1_in,
  input  logic              dt_in,
  output logic              ack_out,
  output logic              senack_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              err_out,
  output state_t            state_dbg
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

  logic [2:0]        synced;
  logic [1:0]        sym;
  logic              dt;
  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              shift_en, cnt_clr, err_nxt;

  sync_bits #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({dt_in, bit1_in, bit0_in}),
    .q     (synced)
  );

  assign sym = synced[1:0];
  assign dt  = synced[2];

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_WAIT: begin
        // A symbol on the rails wins over dt; every non-null symbol is
        // acknowledged, even a bad one, so the sender can always return to zero.
        if (sym != SYM_NULL) begin
          state_nxt = ST_ACK;
          if (sym == SYM_ERR)        err_nxt  = 1'b1;
          else if (cnt < CNT_FULL)   shift_en = 1'b1;
          else                       err_nxt  = 1'b1;
        end else if (dt) begin
          if (cnt == CNT_FULL) begin
            state_nxt = ST_OUT;
          end else begin
            state_nxt = ST_SENACK;
            err_nxt   = 1'b1;
          end
        end
      end
      ST_ACK:    if (sym == SYM_NULL) state_nxt = ST_WAIT;
      ST_OUT:    if (rx_ready)        state_nxt = ST_SENACK;
      ST_SENACK: begin
        if (!dt) begin
          state_nxt = ST_WAIT;
          cnt_clr   = 1'b1;
        end
      end
      default:   state_nxt = ST_WAIT;
    endcase
  end

  // Outputs are flops loaded from the next state so the async sender never
  // sees decode glitches from a multi-bit state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT;
      cnt        <= '0;
      shreg      <= '0;
      err_out    <= 1'b0;
      ack_out    <= 1'b0;
      senack_out <= 1'b0;
      rx_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_out    <= err_nxt;
      ack_out    <= (state_nxt == ST_ACK);
      senack_out <= (state_nxt == ST_SENACK);
      rx_valid   <= (state_nxt == ST_OUT);
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + CW'(1);
      // Shift right with the new bit at the MSB: after DATA_W bits the first
      // one has walked down to bit 0.
      if (shift_en) shreg <= {sym[1], shreg[DATA_W-1:1]};
    end
  end

  assign rx_data   = shreg;
  assign state_dbg = state;

endmodule

// File: tb/tb_dualrail_word_rx.sv
module tb_dualrail_word_rx;
  import dualrail_pkg::*;

  localparam int DW = 8;
  localparam int SS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit0_in = 1'b0, bit1_in = 1'b0, dt_in = 1'b0, rx_ready = 1'b0;
  logic ack_out, senack_out, rx_valid, err_out;
  logic [DW-1:0] rx_data;
  state_t state_dbg;

  always #5 clk = ~clk;

  dualrail_word_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit0_in    (bit0_in),
    .bit1_in    (bit1_in),
    .dt_in      (dt_in),
    .ack_out    (ack_out),
    .senack_out (senack_out),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .err_out    (err_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic          mbits[$];   // bits of the word in progress, in arrival order
  int exp_err = 0, err_seen = 0;
  int exp_acks = 0, ack_seen = 0;
  bit force_ready = 0, hold_ready = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_sym(logic [1:0] s);
    if (s == SYM_ERR)          exp_err++;
    else if (mbits.size() >= DW) exp_err++;
    else                       mbits.push_back(s == SYM_1);
  endtask

  task automatic model_dt();
    logic [DW-1:0] w;
    if (mbits.size() == DW) begin
      for (int i = 0; i < DW; i++) w[i] = mbits[i];
      exp_q.push_back(w);
    end else begin
      exp_err++;
    end
    mbits.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Wait (checking #1 after each edge) for a DUT output to reach lvl.
  task automatic wait_out(int which, logic lvl, int limit, output int n);
    logic v;
    n = 0;
    forever begin
      case (which)
        0:       v = ack_out;
        1:       v = senack_out;
        default: v = rx_valid;
      endcase
      if (v === lvl || n >= limit) break;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drive_sym(logic [1:0] s);
    int n;
    @(posedge clk); #1;
    {bit1_in, bit0_in} = s;
    wait_out(0, 1'b1, 50, n);
    check("ack_rise_latency", n, SS + 1);
    model_sym(s);
    exp_acks++;
    @(posedge clk); #1;
    {bit1_in, bit0_in} = SYM_NULL;
    wait_out(0, 1'b0, 50, n);
    check("ack_fall_latency", n, SS + 1);
  endtask

  task automatic send_bits(logic [15:0] w, int nbits);
    for (int i = 0; i < nbits; i++) drive_sym(w[i] ? SYM_1 : SYM_0);
  endtask

  // dt with whatever the consumer is doing on rx_ready
  task automatic send_dt();
    int n;
    @(posedge clk); #1;
    dt_in = 1'b1;
    model_dt();
    wait_out(1, 1'b1, 400, n);
    check("senack_rise_timeout", (n < 400), 1);
    @(posedge clk); #1;
    dt_in = 1'b0;
    wait_out(1, 1'b0, 50, n);
    check("senack_fall_latency", n, SS + 1);
  endtask

  // dt on a full word with exact latency checks; hold>0 stalls rx_ready
  task automatic dt_word(int hold, logic [DW-1:0] w);
    int n;
    force_ready = (hold == 0);
    hold_ready  = (hold != 0);
    @(posedge clk); #1;
    dt_in = 1'b1;
    model_dt();
    wait_out(2, 1'b1, 50, n);
    check("dt_to_valid_latency", n, SS + 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_valid", rx_valid, 1);
      check("stall_senack", senack_out, 0);
      check("stall_data", rx_data, w);
    end
    force_ready = 1;
    hold_ready  = 0;
    wait_out(1, 1'b1, 50, n);
    check("ready_to_senack_latency", n, 1);
    check("valid_one_cycle", rx_valid, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("senack_held_while_dt", senack_out, 1);
    end
    dt_in = 1'b0;
    wait_out(1, 1'b0, 50, n);
    check("senack_fall_latency", n, SS + 1);
    force_ready = 0;
  endtask

  // ---------------- consumer ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      rx_ready = force_ready ? 1'b1 : hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic prev_v = 0, prev_r = 0, prev_hs = 0, prev_err = 0, prev_ack = 0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hs) check("senack_after_handshake", senack_out, 1);
      if (prev_v && !prev_r) begin
        check("valid_held_until_ready", rx_valid, 1);
        check("data_held_until_ready", rx_data, prev_d);
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %0h want none", rx_data);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (prev_err) check("err_one_cycle", err_out, 0);
      if (err_out && !prev_err) err_seen++;
      if (ack_out && !prev_ack) ack_seen++;
    end
    prev_v   = rx_valid;
    prev_r   = rx_ready;
    prev_d   = rx_data;
    prev_hs  = rx_valid && rx_ready && !reset;
    prev_err = err_out && !reset;
    prev_ack = ack_out;
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int e0, a0, n;
    logic [15:0] w;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", ack_out, 0);
    check("reset_senack", senack_out, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_err", err_out, 0);
    check("reset_data", rx_data, 0);
    check("reset_state", 32'(state_dbg), 32'(ST_WAIT));
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // 1: basic word 0xA5
    a0 = ack_seen;
    send_bits(16'h00A5, 8);
    repeat (2) @(posedge clk);
    check("a5_ack_count", ack_seen - a0, 8);
    dt_word(0, 8'hA5);

    // 2: consumer stalls 20 cycles
    send_bits(16'h003C, 8);
    dt_word(20, 8'h3C);

    // 3: illegal 11 symbol mid-word
    e0 = err_seen;
    send_bits(16'h000A, 4);
    drive_sym(SYM_ERR);
    check("illegal_err_count", err_seen - e0, 1);
    send_bits(16'h0005, 4);
    dt_word(0, 8'h5A);

    // 4: short word
    e0 = err_seen;
    send_bits(16'h0015, 5);
    send_dt();
    check("short_err_count", err_seen - e0, 1);
    check("short_no_word", exp_q.size(), 0);
    send_bits(16'h00C3, 8);
    dt_word(0, 8'hC3);

    // 5: overrun, 9th bit discarded
    e0 = err_seen;
    send_bits(16'h0196, 9);
    check("overrun_err_count", err_seen - e0, 1);
    dt_word(0, 8'h96);

    // 6: reset while a bit is being acknowledged
    send_bits(16'h0007, 3);
    @(posedge clk); #1;
    {bit1_in, bit0_in} = SYM_1;
    wait_out(0, 1'b1, 50, n);
    check("pre_reset_ack", ack_out, 1);
    exp_acks++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_ack", ack_out, 0);
    check("mid_reset_senack", senack_out, 0);
    check("mid_reset_valid", rx_valid, 0);
    check("mid_reset_err", err_out, 0);
    check("mid_reset_data", rx_data, 0);
    reset = 1'b0;
    {bit1_in, bit0_in} = SYM_NULL;
    mbits.delete();
    repeat (4) @(posedge clk);
    send_bits(16'h00FF, 8);
    dt_word(0, 8'hFF);

    // random words against the model
    for (int k = 0; k < 40; k++) begin
      int kind, nb, bad_pos;
      w  = 16'($urandom_range(0, 16'hFFFF));
      kind = $urandom_range(0, 9);
      nb = (kind == 0) ? $urandom_range(1, DW - 1) :
           (kind == 1) ? $urandom_range(DW + 1, DW + 2) : DW;
      bad_pos = (kind == 2) ? $urandom_range(0, nb - 1) : -1;
      for (int i = 0; i < nb; i++) begin
        if (i == bad_pos) drive_sym(SYM_ERR);
        drive_sym(w[i] ? SYM_1 : SYM_0);
      end
      send_dt();
    end

    repeat (10) @(posedge clk);
    #1;
    check("final_err_total", err_seen, exp_err);
    check("final_ack_total", ack_seen, exp_acks);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid_low", rx_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
